// File: rtl/i2c_slave_target.sv
// 7-bit-address I2C target: oversampled SCL/SDA, START/STOP detection, address match,
// ACKed write bytes handed upstream and read bytes shifted out. No clock stretching.
module i2c_slave_target #(
   parameter int DATA_SIZE   = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic                 i2c_core_clk_i,
   input  logic                 reset_i,
   input  logic                 enable_i,
   input  logic [6:0]           own_addr_i,
   input  logic                 scl_i,
   input  logic                 sda_i,
   output logic                 sda_oe_o,
   output logic [DATA_SIZE-1:0] rx_data_o,
   output logic                 rx_valid_o,
   input  logic [DATA_SIZE-1:0] tx_data_i,
   output logic                 tx_load_o,
   output logic                 nack_o,
   output logic                 stop_o,
   output logic                 busy_o
);

   typedef enum logic [2:0] {
      S_IDLE, S_ADDR, S_ADDR_ACK, S_RX_DATA, S_RX_ACK, S_TX_DATA, S_TX_ACK, S_WAIT_STOP
   } state_t;

   localparam logic [3:0] BYTE_BITS = 4'(DATA_SIZE);

   logic [SYNC_STAGES-1:0] r_scl_sync, r_sda_sync;
   logic                   r_scl_prev, r_sda_prev;
   logic                   w_scl, w_sda, w_scl_rise, w_scl_fall, w_start, w_stop;

   state_t                 r_state, w_state_n;
   logic [DATA_SIZE-1:0]   r_shreg, w_shreg_n, r_rx_data, w_rx_data_n;
   logic [3:0]             r_bit_cnt, w_bit_cnt_n;
   logic                   r_rw, w_rw_n, r_ack_bit, w_ack_bit_n, r_sda_oe, w_sda_oe_n;
   logic                   r_rx_valid, w_rx_valid_n, r_nack, w_nack_n, r_stop, w_stop_n;
   logic                   w_tx_load;

   always_ff @(posedge i2c_core_clk_i) begin
      if (reset_i) begin
         r_scl_sync <= '1;
         r_sda_sync <= '1;
         r_scl_prev <= 1'b1;
         r_sda_prev <= 1'b1;
      end else begin
         r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], scl_i};
         r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sda_i};
         r_scl_prev <= w_scl;
         r_sda_prev <= w_sda;
      end
   end

   assign w_scl      = r_scl_sync[SYNC_STAGES-1];
   assign w_sda      = r_sda_sync[SYNC_STAGES-1];
   assign w_scl_rise = w_scl & ~r_scl_prev;
   assign w_scl_fall = ~w_scl & r_scl_prev;
   assign w_start    = w_scl & r_scl_prev & r_sda_prev & ~w_sda;
   assign w_stop     = w_scl & r_scl_prev & ~r_sda_prev & w_sda;

   always_ff @(posedge i2c_core_clk_i) begin
      if (reset_i) begin
         r_state    <= S_IDLE;
         r_shreg    <= '0;
         r_bit_cnt  <= '0;
         r_rw       <= 1'b0;
         r_ack_bit  <= 1'b0;
         r_sda_oe   <= 1'b0;
         r_rx_data  <= '0;
         r_rx_valid <= 1'b0;
         r_nack     <= 1'b0;
         r_stop     <= 1'b0;
      end else begin
         r_state    <= w_state_n;
         r_shreg    <= w_shreg_n;
         r_bit_cnt  <= w_bit_cnt_n;
         r_rw       <= w_rw_n;
         r_ack_bit  <= w_ack_bit_n;
         r_sda_oe   <= w_sda_oe_n;
         r_rx_data  <= w_rx_data_n;
         r_rx_valid <= w_rx_valid_n;
         r_nack     <= w_nack_n;
         r_stop     <= w_stop_n;
      end
   end

   // Bus conditions and disable pre-empt any SCL edge seen in the same cycle.
   always_comb begin
      w_state_n    = r_state;
      w_shreg_n    = r_shreg;
      w_bit_cnt_n  = r_bit_cnt;
      w_rw_n       = r_rw;
      w_ack_bit_n  = r_ack_bit;
      w_sda_oe_n   = r_sda_oe;
      w_rx_data_n  = r_rx_data;
      w_rx_valid_n = 1'b0;
      w_nack_n     = 1'b0;
      w_stop_n     = 1'b0;
      w_tx_load    = 1'b0;
      if (w_stop) begin
         w_state_n  = S_IDLE;
         w_sda_oe_n = 1'b0;
         w_stop_n   = 1'b1;
      end else if (w_start) begin
         w_state_n   = S_ADDR;
         w_bit_cnt_n = '0;
         w_sda_oe_n  = 1'b0;
      end else if (!enable_i) begin
         w_state_n  = S_IDLE;
         w_sda_oe_n = 1'b0;
      end else begin
         case (r_state)
            S_ADDR, S_RX_DATA: begin
               if (w_scl_rise) begin
                  w_shreg_n   = {r_shreg[DATA_SIZE-2:0], w_sda};
                  w_bit_cnt_n = r_bit_cnt + 4'd1;
               end else if (w_scl_fall && (r_bit_cnt == BYTE_BITS)) begin
                  if (r_state == S_RX_DATA) begin
                     w_rx_data_n  = r_shreg;
                     w_rx_valid_n = 1'b1;
                     w_sda_oe_n   = 1'b1;
                     w_state_n    = S_RX_ACK;
                  end else if (r_shreg[DATA_SIZE-1:1] == own_addr_i) begin
                     w_rw_n     = r_shreg[0];
                     w_sda_oe_n = 1'b1;
                     w_state_n  = S_ADDR_ACK;
                  end else begin
                     w_sda_oe_n = 1'b0;
                     w_state_n  = S_WAIT_STOP;
                  end
               end
            end
            S_ADDR_ACK: begin
               if (w_scl_fall) begin
                  w_bit_cnt_n = '0;
                  if (r_rw) begin
                     w_shreg_n  = tx_data_i;
                     w_tx_load  = 1'b1;
                     w_sda_oe_n = ~tx_data_i[DATA_SIZE-1];
                     w_state_n  = S_TX_DATA;
                  end else begin
                     w_sda_oe_n = 1'b0;
                     w_state_n  = S_RX_DATA;
                  end
               end
            end
            S_RX_ACK: begin
               if (w_scl_fall) begin
                  w_sda_oe_n  = 1'b0;
                  w_bit_cnt_n = '0;
                  w_state_n   = S_RX_DATA;
               end
            end
            S_TX_DATA: begin
               if (w_scl_rise) begin
                  w_bit_cnt_n = r_bit_cnt + 4'd1;
               end else if (w_scl_fall) begin
                  if (r_bit_cnt < BYTE_BITS) begin
                     w_shreg_n  = {r_shreg[DATA_SIZE-2:0], 1'b0};
                     w_sda_oe_n = ~r_shreg[DATA_SIZE-2];
                  end else begin
                     w_sda_oe_n = 1'b0;
                     w_state_n  = S_TX_ACK;
                  end
               end
            end
            S_TX_ACK: begin
               if (w_scl_rise) begin
                  w_ack_bit_n = w_sda;
               end else if (w_scl_fall) begin
                  if (!r_ack_bit) begin
                     w_shreg_n   = tx_data_i;
                     w_tx_load   = 1'b1;
                     w_bit_cnt_n = '0;
                     w_sda_oe_n  = ~tx_data_i[DATA_SIZE-1];
                     w_state_n   = S_TX_DATA;
                  end else begin
                     w_nack_n   = 1'b1;
                     w_sda_oe_n = 1'b0;
                     w_state_n  = S_WAIT_STOP;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign sda_oe_o   = r_sda_oe;
   assign rx_data_o  = r_rx_data;
   assign rx_valid_o = r_rx_valid;
   assign nack_o     = r_nack;
   assign stop_o     = r_stop;
   // Combinational so tx_data_i is captured in the very cycle this pulse is seen.
   assign tx_load_o  = w_tx_load & ~reset_i;
   assign busy_o     = r_state inside {S_ADDR_ACK, S_RX_DATA, S_RX_ACK, S_TX_DATA, S_TX_ACK};

endmodule

// File: doc/i2c_slave_target.md
# i2c_slave_target

Responder end of the I2C bus driven by `i2c_top`: a 7-bit-address I2C target (slave) running on the I2C core clock. It oversamples `scl`/`sda`, detects START, repeated START and STOP, and matches its own address. It ACKs write bytes and hands them upstream, and shifts out read bytes supplied upstream. Used as an on-die loopback/bench partner for the master and as the target core for a future target-mode APB wrapper. No clock stretching.

## Interface
- `DATA_SIZE`, 8, byte width. Only 8 is supported.
- `SYNC_STAGES`, 2, flops in each input synchronizer. Minimum 2.
- `i2c_core_clk_i` in 1: core clock; the only clock.
- `reset_i` in 1: synchronous, active-high reset.
- `enable_i` in 1: target enable. When low, the block never ACKs.
- `own_addr_i` in 7: own 7-bit address. Must be static while busy.
- `scl_i` in 1: raw bus SCL (asynchronous).
- `sda_i` in 1: raw bus SDA (asynchronous).
- `sda_oe_o` out 1: 1 pulls SDA low, 0 releases it. Open-drain; the pad does `sda = sda_oe_o ? 0 : z`.
- `rx_data_o` out DATA_SIZE: last received write byte. Held until the next byte.
- `rx_valid_o` out 1: one-cycle pulse when `rx_data_o` updates.
- `tx_data_i` in DATA_SIZE: next read byte. Sampled in the cycle `tx_load_o` is high.
- `tx_load_o` out 1: one-cycle pulse when `tx_data_i` is captured. Upstream advances on it.
- `nack_o` out 1: one-cycle pulse when the master NACKs a read byte.
- `stop_o` out 1: one-cycle pulse on a detected STOP.
- `busy_o` out 1: high while addressed, from address ACK until STOP, START or NACK.

## Operation
- Input synchronization:
  - `scl_i` and `sda_i` each pass through SYNC_STAGES flops, then one "previous" flop.
  - scl_rise = synchronized 1, previous 0. scl_fall = synchronized 0, previous 1.
- Bus conditions:
  - START = SDA falls while synchronized SCL and previous SCL are both 1.
  - STOP = SDA rises under the same SCL condition.
- Priority, from any state:
  - STOP: go to IDLE, `sda_oe_o`=0, pulse `stop_o`.
  - START (includes repeated START): go to ADDR, bit_cnt=0, `sda_oe_o`=0.
  - `enable_i`=0: go to IDLE, `sda_oe_o`=0.
  - These win over any SCL edge in the same cycle.
- States:
  - IDLE: wait for START.
  - ADDR: on each scl_rise, shift `sda` into shreg (MSB first) and increment bit_cnt. On the scl_fall after the 8th bit:
    - If shreg[7:1]==`own_addr_i` and `enable_i`: latch rw=shreg[0], set `sda_oe_o`=1, go to ADDR_ACK.
    - Otherwise: go to WAIT_STOP with SDA released.
  - ADDR_ACK: on scl_fall, clear bit_cnt.
    - rw=0: set `sda_oe_o`=0, go to RX_DATA.
    - rw=1: load shreg from `tx_data_i`, pulse `tx_load_o`, set `sda_oe_o`=~tx_data_i[7], go to TX_DATA.
  - RX_DATA: shift on scl_rise. On the scl_fall after the 8th bit: `rx_data_o`=shreg, pulse `rx_valid_o`, set `sda_oe_o`=1, go to RX_ACK.
  - RX_ACK: on scl_fall, set `sda_oe_o`=0, clear bit_cnt, go to RX_DATA. Every byte is always ACKed; there is no overflow check.
  - TX_DATA: on scl_rise, increment bit_cnt. On scl_fall:
    - bit_cnt<8: shift shreg left, set `sda_oe_o`=~shreg[6].
    - bit_cnt==8: set `sda_oe_o`=0, go to TX_ACK.
  - TX_ACK: on scl_rise, sample SDA into ack_bit. On the following scl_fall:
    - ack_bit=0: load `tx_data_i`, pulse `tx_load_o`, clear bit_cnt, drive the MSB, go to TX_DATA.
    - ack_bit=1: pulse `nack_o`, go to WAIT_STOP.
  - WAIT_STOP: SDA released. Leave only via STOP, START or `enable_i`=0.
- bit_cnt is 4 bits and counts 0..8. It never wraps, because it is cleared on every byte boundary.
- `busy_o` is 1 in ADDR_ACK, RX_DATA, RX_ACK, TX_DATA and TX_ACK.

## Timing
- Reset values: all outputs 0, `rx_data_o`=0, state IDLE, synchronizer and previous flops = 1 (bus idle).
- Latency from pin to detected edge: SYNC_STAGES+1 cycles.
- `sda_oe_o` changes in the cycle after the detected scl_fall, i.e. SYNC_STAGES+2 cycles after the pin edge.
- Bus requirement: SCL high and low phases each ≥ SYNC_STAGES+4 core clocks. With the default, SCL period ≥ 12 core clocks.
- The master must hold SDA ≥ SYNC_STAGES+2 core clocks after its own SCL fall. This avoids a false START/STOP.
- `rx_valid_o`, `tx_load_o`, `nack_o` and `stop_o` are exactly one cycle each and mutually exclusive in any cycle.
- Reset asserted mid-byte: IDLE on the next edge, SDA released that cycle, partial byte discarded, no pulses.

## Test plan
- Write transfer: own_addr=0x50. Master sends START, 0xA0, 0x3C, 0xC3, STOP.
  - Required: `sda_oe_o` high during each of the 3 ACK bits.
  - `rx_valid_o` pulses twice with `rx_data_o`=0x3C then 0xC3.
  - `stop_o` pulses once; `busy_o` falls with STOP.
- Address mismatch: master sends 0xA2 with own_addr=0x50.
  - Required: `sda_oe_o` stays 0 for the whole frame, no pulses, `busy_o`=0, `stop_o` pulses at STOP.
- Read transfer: master sends 0xA1; `tx_data_i`=0x5A, then 0x81 after the first `tx_load_o`; master ACKs byte 1, NACKs byte 2, then STOP.
  - Required: SDA bits 01011010 then 10000001.
  - `tx_load_o` pulses twice; `nack_o` pulses once after byte 2; SDA released afterwards.
- Repeated START: write 0xA0, 0x10, then repeated START and 0xA1 read of one byte.
  - Required: state re-enters ADDR, rw switches to 1, and one `tx_load_o` follows the second address ACK.
- Disable and reset mid-operation:
  - `enable_i` dropped during RX bit 4: `sda_oe_o`=0 next cycle, no `rx_valid_o`.
  - `reset_i` during the TX ACK phase: all outputs 0 on the next cycle.
  - A following 0xA0 frame after re-enable is ACKed normally.
